// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and defaults.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FULL,
    S_DRAIN
  } fetchState_t;

  localparam int unsigned DEF_W        = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating event counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request at a time, IF/ID
// pipeline register, branch/jump redirect and stall/flush statistics.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned    W        = DEF_W,
  parameter logic [W-1:0]   RESET_PC = W'(DEF_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         PCSrcD,
  input  logic [W-1:0] PCBranchD,
  input  logic         JumpD,
  input  logic [W-1:0] PCJumpD,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_rdata,
  output logic [W-1:0] InstrD,
  output logic [W-1:0] PCPlus4D,
  output logic         ValidD,
  output logic         FetchBusy,
  output logic [31:0]  stall_count,
  output logic [31:0]  flush_count
);

  fetchState_t  state;
  logic [W-1:0] pcF;
  logic [W-1:0] holding;
  logic         redirect;
  logic [W-1:0] target;
  logic [W-1:0] pcPlus4;

  always_comb begin
    redirect = ValidD & ~StallD & (PCSrcD | JumpD);
    target   = PCSrcD ? PCBranchD : PCJumpD;
    pcPlus4  = pcF + W'(4);
  end

  assign FetchBusy = imem_req;

  // A redirect never cancels an in-flight request: without an ack the FSM
  // drains it in DRAIN, with an ack the data is dropped and WAIT restarts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pcF       <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      holding   <= W'(NOP_INSTR);
      InstrD    <= W'(NOP_INSTR);
      PCPlus4D  <= '0;
      ValidD    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_WAIT;
          imem_req  <= 1'b1;
          imem_addr <= pcF;
        end
        S_WAIT: begin
          if (!StallD) begin
            InstrD   <= W'(NOP_INSTR);
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
          end
          if (redirect) begin
            pcF <= target;
            if (imem_ack) begin
              imem_addr <= target;
            end else begin
              state <= S_DRAIN;
            end
          end else if (imem_ack) begin
            holding  <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_FULL;
          end
        end
        S_FULL: begin
          if (!StallD) begin
            state    <= S_WAIT;
            imem_req <= 1'b1;
            if (redirect) begin
              pcF       <= target;
              imem_addr <= target;
              holding   <= W'(NOP_INSTR);
              InstrD    <= W'(NOP_INSTR);
              PCPlus4D  <= '0;
              ValidD    <= 1'b0;
            end else begin
              InstrD   <= holding;
              PCPlus4D <= pcPlus4;
              ValidD   <= 1'b1;
              if (StallF) begin
                imem_addr <= pcF;
              end else begin
                pcF       <= pcPlus4;
                imem_addr <= pcPlus4;
              end
            end
          end
        end
        S_DRAIN: begin
          if (!StallD) begin
            InstrD   <= W'(NOP_INSTR);
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
          end
          if (redirect) begin
            pcF <= target;
          end
          if (imem_ack) begin
            state     <= S_WAIT;
            imem_addr <= redirect ? target : pcF;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(32)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (StallD & ValidD),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(32)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .count (flush_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural model compared every cycle
// plus directed scenarios with literal expectations.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, StallF, StallD, PCSrcD, JumpD;
  logic [31:0] PCBranchD, PCJumpD;
  logic        imem_req, ValidD, FetchBusy;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_addr, InstrD, PCPlus4D, stall_count, flush_count;
  logic [31:0] imem_rdata = 32'h0;

  logic        req2, valid2, busy2;
  logic        ack2 = 1'b0;
  logic [31:0] addr2, instr2, pc4_2, sc2, fc2;
  logic [31:0] rdata2 = 32'h0;

  fetch_stage #(.W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FetchBusy(FetchBusy),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  fetch_stage #(.W(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst_n(rst_n), .StallF(1'b0), .StallD(1'b0),
    .PCSrcD(1'b0), .PCBranchD(32'h0), .JumpD(1'b0), .PCJumpD(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata2), .InstrD(instr2), .PCPlus4D(pc4_2),
    .ValidD(valid2), .FetchBusy(busy2),
    .stall_count(sc2), .flush_count(fc2)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a + 32'h1000_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks each request `lat` cycles after it first appears.
  int          lat = 2;
  bit          manualAck = 1'b0;
  bit          manualAckVal = 1'b0;
  bit          reqSeen = 1'b0;
  int          age = 0;
  logic [31:0] addrLog[$];

  always @(negedge clk) begin
    #1;
    if (manualAck) begin
      imem_ack   = manualAckVal;
      imem_rdata = memWord(imem_addr);
    end else begin
      if (imem_ack) reqSeen = 1'b0;
      imem_ack = 1'b0;
      if (imem_req === 1'b1) begin
        if (!reqSeen) begin
          reqSeen = 1'b1;
          age     = 0;
        end else begin
          age++;
        end
        if (age == lat) begin
          imem_ack   = 1'b1;
          imem_rdata = memWord(imem_addr);
          addrLog.push_back(imem_addr);
        end
      end else begin
        reqSeen = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    ack2   = (req2 === 1'b1) && !ack2;
    rdata2 = memWord(addr2);
  end

  // Behavioural model: tracks "request outstanding", "next reply to be
  // dropped" and "fetched word waiting for Decode" rather than FSM states.
  logic [31:0] mPC, mAddr, mHold, mInstr, mPC4, mStall, mFlush, staleAddr;
  bit          mInit = 1'b0, mStarted, mReq, mDrop, mHave, mValid;
  bit          staleArmed = 1'b0, staleSeen = 1'b0;

  task automatic modelStep();
    bit          redir;
    logic [31:0] tgt;
    if (rst_n === 1'b0) begin
      mInit = 1'b1; mStarted = 1'b0; mReq = 1'b0; mDrop = 1'b0; mHave = 1'b0;
      mPC = 32'h0; mAddr = 32'h0; mHold = 32'h0;
      mInstr = 32'h0; mPC4 = 32'h0; mValid = 1'b0;
      mStall = 32'h0; mFlush = 32'h0;
      return;
    end
    if (!mInit) return;
    redir = mValid && !StallD && (PCSrcD || JumpD);
    tgt   = PCSrcD ? PCBranchD : PCJumpD;
    if (mValid && StallD && mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
    if (redir && mFlush != 32'hFFFF_FFFF) mFlush = mFlush + 1;
    if (!mStarted) begin
      mStarted = 1'b1; mReq = 1'b1; mAddr = mPC;
    end else if (mHave) begin
      if (!StallD) begin
        if (redir) begin
          mPC = tgt; mInstr = 32'h0; mPC4 = 32'h0; mValid = 1'b0;
        end else begin
          mInstr = mHold; mPC4 = mPC + 32'd4; mValid = 1'b1;
          if (!StallF) mPC = mPC + 32'd4;
        end
        mHave = 1'b0; mReq = 1'b1; mAddr = mPC;
      end
    end else begin
      if (!StallD) begin
        mInstr = 32'h0; mPC4 = 32'h0; mValid = 1'b0;
      end
      if (redir) mPC = tgt;
      if (imem_ack) begin
        if (mDrop || redir) begin
          mDrop = 1'b0; mAddr = mPC;
        end else begin
          mHold = memWord(mAddr); mHave = 1'b1; mReq = 1'b0;
        end
      end else if (redir) begin
        mDrop = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep();
    #2;
    if (mInit) begin
      chk("m_req",    imem_req,    mReq);
      chk("m_busy",   FetchBusy,   mReq);
      chk("m_addr",   imem_addr,   mAddr);
      chk("m_instr",  InstrD,      mInstr);
      chk("m_pc4",    PCPlus4D,    mPC4);
      chk("m_valid",  ValidD,      mValid);
      chk("m_stalls", stall_count, mStall);
      chk("m_flushes", flush_count, mFlush);
      if (staleArmed && ValidD === 1'b1 && InstrD === memWord(staleAddr)) staleSeen = 1'b1;
    end
  end

  function automatic bit cond(input int sel);
    case (sel)
      0:       return ValidD === 1'b1;
      1:       return ValidD === 1'b0;
      2:       return imem_req === 1'b0;
      3:       return imem_req === 1'b1;
      default: return imem_addr !== 32'h44;
    endcase
  endfunction

  task automatic waitFor(input string name, input int sel);
    int n = 0;
    while (!cond(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cond(sel)) begin
      total++;
      bad++;
      $display("FAIL timeout_%s: waited %0d cycles, required condition within 50", name, n);
    end
  endtask

  logic [31:0] heldAddr, s0;

  initial begin
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    PCBranchD = 32'h0; PCJumpD = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_req",    imem_req,    32'h0);
    chk("reset_addr",   imem_addr,   32'h0);
    chk("reset_valid",  ValidD,      32'h0);
    chk("reset_instr",  InstrD,      32'h0);
    chk("reset_stalls", stall_count, 32'h0);
    chk("reset_wrap_addr", addr2,    32'hFFFF_FFFC);
    rst_n = 1'b1;

    // RESET_PC at the top of the address space wraps to 0
    for (int i = 0; i < 20 && valid2 !== 1'b1; i++) @(negedge clk);
    chk("wrap_valid",     valid2, 32'h1);
    chk("wrap_pcplus4",   pc4_2,  32'h0);
    chk("wrap_instr",     instr2, memWord(32'hFFFF_FFFC));
    chk("wrap_next_addr", addr2,  32'h0);

    // Sequential fetch, no stalls
    repeat (16) @(negedge clk);
    chk("seq_log_len", 32'(addrLog.size() >= 3), 32'h1);
    chk("seq_addr0", addrLog[0], 32'h0);
    chk("seq_addr1", addrLog[1], 32'h4);
    chk("seq_addr2", addrLog[2], 32'h8);

    // Decode stall held across WAIT and 3 FULL cycles
    waitFor("valid_before_stall", 0);
    heldAddr = addrLog[addrLog.size() - 1];
    StallD = 1'b1; StallF = 1'b1;
    waitFor("full_for_stall", 2);
    s0 = stall_count;
    repeat (3) @(negedge clk);
    chk("stall_delta", stall_count - s0, 32'd3);
    chk("stall_instr", InstrD, memWord(heldAddr));
    chk("stall_noreq", imem_req, 32'h0);

    // Release into a taken branch (PCSrcD beats JumpD)
    StallD = 1'b0; StallF = 1'b0;
    PCSrcD = 1'b1; PCBranchD = 32'h40; JumpD = 1'b1; PCJumpD = 32'h80;
    @(negedge clk);
    PCSrcD = 1'b0; JumpD = 1'b0;
    chk("br_valid", ValidD,      32'h0);
    chk("br_addr",  imem_addr,   32'h40);
    chk("br_req",   imem_req,    32'h1);
    chk("br_flush", flush_count, 32'h1);

    // Jump while WAIT on 0x44: reply is drained and dropped
    lat = 3;
    waitFor("valid_before_jump", 0);
    chk("jmp_old_addr", imem_addr, 32'h44);
    staleAddr = 32'h44; staleArmed = 1'b1;
    JumpD = 1'b1; PCJumpD = 32'h100;
    @(negedge clk);
    JumpD = 1'b0;
    chk("drain_req",   imem_req,  32'h1);
    chk("drain_addr",  imem_addr, 32'h44);
    chk("drain_valid", ValidD,    32'h0);
    waitFor("addr_change", 4);
    chk("jmp_new_addr", imem_addr, 32'h100);
    waitFor("valid_after_jump", 0);
    chk("jmp_instr", InstrD,      memWord(32'h100));
    chk("jmp_pc4",   PCPlus4D,    32'h104);
    chk("jmp_flush", flush_count, 32'h2);
    chk("no_stale",  32'(staleSeen), 32'h0);
    staleArmed = 1'b0;

    // StallF alone: instruction passes to Decode, PC is held
    waitFor("full_for_stallf", 2);
    StallF = 1'b1;
    @(negedge clk);
    StallF = 1'b0;
    chk("stallf_addr",  imem_addr, 32'h104);
    chk("stallf_pc4",   PCPlus4D,  32'h108);
    chk("stallf_instr", InstrD,    memWord(32'h104));

    // Redirect in the same cycle as the ack
    lat = 0;
    waitFor("bubble_before_ackbr", 1);
    waitFor("valid_before_ackbr", 0);
    PCSrcD = 1'b1; PCBranchD = 32'h200;
    @(negedge clk);
    PCSrcD = 1'b0;
    chk("ackbr_addr",  imem_addr,   32'h200);
    chk("ackbr_req",   imem_req,    32'h1);
    chk("ackbr_valid", ValidD,      32'h0);
    chk("ackbr_flush", flush_count, 32'h3);
    repeat (4) @(negedge clk);

    // Reset while WAIT, ack arrives in the IDLE cycle after reset
    manualAck = 1'b1; manualAckVal = 1'b0;
    @(negedge clk);
    waitFor("req_before_reset", 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; manualAckVal = 1'b1;
    chk("rst_idle_req",   imem_req,    32'h0);
    chk("rst_idle_addr",  imem_addr,   32'h0);
    chk("rst_idle_flush", flush_count, 32'h0);
    @(negedge clk);
    manualAckVal = 1'b0;
    chk("rst_wait_req",   imem_req,  32'h1);
    chk("rst_wait_addr",  imem_addr, 32'h0);
    chk("rst_wait_valid", ValidD,    32'h0);
    @(negedge clk);
    lat = 2; manualAck = 1'b0;
    waitFor("valid_after_reset", 0);
    chk("rst_instr", InstrD,   memWord(32'h0));
    chk("rst_pc4",   PCPlus4D, 32'h4);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: W, 32, datapath/address width.
REQ-002 Parameter: RESET_PC, 0, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 StallF  input  1  from hazard unit; hold PCF.
REQ-006 StallD  input  1  from hazard unit; hold IF/ID register.
REQ-007 PCSrcD  input  1  branch taken, resolved in Decode.
REQ-008 PCBranchD  input  W  branch target.
REQ-009 JumpD  input  1  jump in Decode.
REQ-010 PCJumpD  input  W  jump target.
REQ-011 imem_req  output  1  instruction-memory request; level, held until ack.
REQ-012 imem_addr  output  W  request address; stable while imem_req=1.
REQ-013 imem_ack  input  1  one-cycle pulse; imem_rdata valid in that cycle.
REQ-014 imem_rdata  input  W  fetched instruction.
REQ-015 InstrD  output  W  IF/ID instruction.
REQ-016 PCPlus4D  output  W  IF/ID PC+4.
REQ-017 ValidD  output  1  IF/ID holds a real instruction; 0 = bubble.
REQ-018 FetchBusy  output  1  memory request outstanding (state WAIT or DRAIN).
REQ-019 stall_count  output  32  saturating count of Decode stall cycles.
REQ-020 flush_count  output  32  saturating count of taken redirects.

Function
REQ-021 FSM states IDLE, WAIT, FULL, DRAIN; imem_req SHALL be 1 exactly in WAIT and DRAIN.
REQ-022 IDLE -> WAIT unconditionally next cycle; imem_addr <= PCF on every entry to WAIT.
REQ-023 WAIT: on imem_ack, capture imem_rdata into holding register, go to FULL; without ack, remain.
REQ-024 FULL, StallD=0, no redirect: InstrD <= holding, PCPlus4D <= PCF+4, ValidD <= 1; PCF <= PCF+4 unless StallF; go to WAIT.
REQ-025 FULL, StallD=1: IF/ID, PCF, holding register unchanged; remain FULL.
REQ-026 Redirect = ValidD & ~StallD & (PCSrcD | JumpD); target = PCBranchD if PCSrcD, else PCJumpD (PCSrcD has priority).
REQ-027 Redirect in FULL: PCF <= target, holding discarded, InstrD <= 0, ValidD <= 0, go to WAIT.
REQ-028 Redirect in WAIT without ack: PCF <= target, IF/ID cleared, go to DRAIN; outstanding request is never cancelled.
REQ-029 Redirect in WAIT with ack in same cycle: returned data discarded, PCF <= target, next state WAIT with new address.
REQ-030 DRAIN: on imem_ack, discard data, go to WAIT (imem_addr <= redirected PCF).
REQ-031 In WAIT/DRAIN with StallD=0 and no redirect, IF/ID SHALL load a bubble (InstrD=0, ValidD=0).
REQ-032 PC+4 arithmetic modulo 2^W; 0xFFFFFFFC+4 wraps to 0.
REQ-033 stall_count increments when StallD & ValidD; flush_count increments on each redirect; both hold at 0xFFFFFFFF.
REQ-034 imem_addr and imem_req SHALL NOT change while a request is outstanding and unacknowledged.

Reset
REQ-035 With rst_n=0 at clk edge: state IDLE, PCF=RESET_PC, imem_addr=RESET_PC, imem_req=0, InstrD=0, PCPlus4D=0, ValidD=0, counters=0, holding cleared.
REQ-036 Reset mid-request SHALL abandon it; an ack in the first cycle after reset is ignored (state IDLE).

Structure
REQ-037 Shared package holds FSM state enum, RESET_PC default, W default, NOP encoding 0.
REQ-038 One sub-module, sat_counter (32-bit, increment enable, synchronous active-low clear), instantiated twice.
REQ-039 All outputs registered; no combinational path from inputs to imem_req/imem_addr.

Verification
REQ-040 Reset, ack 2 cycles after each req, no stalls: imem_addr sequence 0,4,8; InstrD follows rdata; ValidD=1 when loaded.
REQ-041 FULL with StallD=StallF=1 for 3 cycles: InstrD, PCF unchanged; stall_count +3; no new req.
REQ-042 ValidD=1, PCSrcD=1, PCBranchD=0x40 in FULL: ValidD=0 next cycle, imem_addr=0x40, flush_count=1.
REQ-043 JumpD=1, PCJumpD=0x100 during WAIT, ack 3 cycles later: old data dropped, next imem_addr=0x100, no instruction from old address reaches InstrD.
REQ-044 RESET_PC=0xFFFFFFFC: PCPlus4D=0, next imem_addr=0.
REQ-045 rst_n=0 for 1 cycle while in WAIT, ack next cycle: state IDLE, ack ignored, then req at RESET_PC.
